regfile_2r1w: RTL and testbench
===============================

// Module: regfile_2r1w
// PURPOSE
//  Parametrised register file: two synchronous read ports, one write port, write-to-read bypass.
//  Optional hardwired-zero register 0.
//  Bulk clear (reset or clear_req) runs as a sequential sweep, one entry per cycle, so the array maps to RAM.
//  Sits in the datapath between decode (read addresses) and writeback (write port); busy stalls the core FSM.
// PARAMETERS
//  DATA_W     32  register width in bits
//  DEPTH      16  number of registers, >=2, need not be a power of two
//  ZERO_REG0  1   1: reg 0 reads 0, writes to it dropped, sweep skips it; 0: reg 0 is ordinary
//  ADDR_W     localparam = $clog2(DEPTH)
// PORTS
//  clk        in   1       clock, all logic on posedge
//  reset      in   1       reset, synchronous, active-high
//  clear_req  in   1       request bulk clear of all registers (instruction-level reg reset)
//  busy       out  1       1 while clear sweep in progress; writes dropped, reads return 0
//  clr_done   out  1       one-cycle pulse on the cycle busy falls
//  we         in   1       write enable
//  waddr      in   ADDR_W  write address
//  wdata      in   DATA_W  write data
//  raddr_a    in   ADDR_W  read address, port A
//  rdata_a    out  DATA_W  read data A, registered, 1-cycle latency
//  raddr_b    in   ADDR_W  read address, port B
//  rdata_b    out  DATA_W  read data B, registered, 1-cycle latency
// BEHAVIOUR
//  - Reset values: busy=1, clr_done=0, rdata_a=rdata_b=0, state=CLEAR, ptr=FIRST.
//    FIRST = ZERO_REG0 ? 1 : 0.
//  - FSM IDLE/CLEAR:
//    - IDLE + clear_req -> CLEAR, ptr<=FIRST.
//    - CLEAR: mem[ptr]<=0 each cycle, ptr++.
//    - At ptr==DEPTH-1: CLEAR -> IDLE and clr_done<=1 for one cycle.
//  - Sweep length: DEPTH-FIRST cycles after reset falls or after the clear_req cycle.
//    Example: DEPTH=16, ZERO_REG0=1 gives 15 cycles.
//  - busy is registered: busy = (state==CLEAR).
//  - clear_req while in CLEAR is ignored; it does not restart the sweep.
//  - Reset mid-sweep restarts the sweep at FIRST.
//  - Write: performed when we && state==IDLE && !clear_req && waddr<DEPTH && !(ZERO_REG0 && waddr==0).
//    Otherwise the write is silently dropped.
//    We and clear_req in the same IDLE cycle: clear wins, write dropped.
//  - Read, per port, evaluated each cycle; first matching rule wins:
//    1. state==CLEAR or raddr>=DEPTH or (ZERO_REG0 && raddr==0): rdata<=0.
//    2. Write performed this cycle and waddr==raddr: rdata<=wdata (bypass).
//    3. Otherwise: rdata<=mem[raddr] (pre-write value).
//  - Both ports may read the same address; both get identical data.
//  - Read latency is exactly 1 cycle.
//    rdata holds its value only while the address is unchanged; no enable.
//  - Storage: DATA_W x DEPTH array.
//    No per-entry reset beyond the sweep; contents before the first sweep completes are don't-care.
// STRUCTURE
//  - Shared package nucore_pkg:
//    - RF_IDLE/RF_CLEAR state encodings.
//    - Default RF_DATA_W=32 and RF_DEPTH=16.
//  - Sub-module rf_clear_seq (FSM, ptr counter, busy, clr_done; outputs clr_we/clr_addr).
//  - Top level: write-qualify mux, storage array, two read/bypass units (generate loop over ports).
// TESTING
//  1. Reset 1 cycle, DEPTH=16, ZERO_REG0=1.
//     -> busy=1 for 15 cycles after reset falls; clr_done pulses once; then all reads return 0.
//  2. Write r3=0xDEADBEEF; next cycle raddr_a=3.
//     -> rdata_a=0xDEADBEEF one cycle later.
//  3. Same-cycle we waddr=5 wdata=0x1234 with raddr_a=raddr_b=5.
//     -> both rdata=0x1234 next cycle (bypass).
//  4. Write r0=0xFFFFFFFF (ZERO_REG0=1) -> read r0 returns 0.
//     Rerun with ZERO_REG0=0 -> read r0 returns 0xFFFFFFFF.
//  5. Fill r1..r15 with nonzero values, then pulse clear_req together with we r7=0x55.
//     -> write dropped; sweep runs 15 cycles; writes during busy dropped; all regs read 0 after.
//  6. DEPTH=12: write waddr=13 then read raddr=13 -> write dropped, rdata=0.
//     Also assert reset at sweep cycle 6 -> sweep restarts, busy held 11 more cycles.

Source files
------------

// File: rtl/nucore_pkg.sv
// Shared core definitions: register-file clear FSM encodings and default geometry.
package nucore_pkg;

    // Clear-sequencer states: IDLE serves normal traffic, CLEAR sweeps the array.
    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 16;

    // First entry the clear sweep touches: a hardwired-zero reg 0 never needs clearing.
    function automatic int rf_first_entry(input int zero_reg0);
        int first_v;
        if (zero_reg0 != 0) begin
            first_v = 1;
        end else begin
            first_v = 0;
        end
        return first_v;
    endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Bulk-clear sequencer for the register file: walks a pointer over the
// array one entry per cycle, raising busy for the whole sweep and pulsing
// clr_done on the cycle busy falls.
module rf_clear_seq
    import nucore_pkg::*;
#(
    parameter int DEPTH     = RF_DEPTH,
    parameter int ZERO_REG0 = 1,
    parameter int ADDR_W    = $clog2(RF_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_done,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(rf_first_entry(ZERO_REG0));
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_ADDR   = ADDR_W'(1);

    rf_state_e         state_q;
    rf_state_e         state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic              busy_q;
    logic              busy_d;
    logic              clr_done_q;
    logic              clr_done_d;

    // State register: reset starts (or restarts) the sweep at the first clearable entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RF_CLEAR;
            ptr_q      <= FIRST_ADDR;
            busy_q     <= 1'b1;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            clr_done_q <= clr_done_d;
        end
    end

    // Next-state logic: a request in CLEAR is ignored so the sweep never restarts mid-way.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            RF_IDLE: begin
                if (clear_req) begin
                    state_d = RF_CLEAR;
                    ptr_d   = FIRST_ADDR;
                end else begin
                    state_d = RF_IDLE;
                    ptr_d   = ptr_q;
                end
            end
            RF_CLEAR: begin
                if (ptr_q == LAST_ADDR) begin
                    state_d = RF_IDLE;
                    ptr_d   = FIRST_ADDR;
                end else begin
                    state_d = RF_CLEAR;
                    ptr_d   = ptr_q + ONE_ADDR;
                end
            end
            default: begin
                state_d = RF_CLEAR;
                ptr_d   = FIRST_ADDR;
            end
        endcase
    end

    // Output logic: busy mirrors the next state so it is a clean flop; clear writes come straight off ptr.
    always_comb begin
        busy_d     = (state_d == RF_CLEAR);
        clr_done_d = (state_q == RF_CLEAR) && (state_d == RF_IDLE);
        clr_we     = (state_q == RF_CLEAR);
        clr_addr   = ptr_q;
    end

    assign busy     = busy_q;
    assign clr_done = clr_done_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with write-to-read bypass, optional
// hardwired-zero reg 0 and a sequential bulk clear that keeps the storage
// free of per-entry reset so it can map onto RAM.
module regfile_2r1w
    import nucore_pkg::*;
#(
    parameter int  DATA_W    = RF_DATA_W,
    parameter int  DEPTH     = RF_DEPTH,
    parameter int  ZERO_REG0 = 1,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_done,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    // True when the address names a physical entry (DEPTH need not be a power of two).
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DEPTH_EXT);
    endfunction

    // True when the address is the hardwired-zero register.
    function automatic logic is_hard_zero(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG0 != 0) && (addr == {ADDR_W{1'b0}});
    endfunction

    logic              busy_s;
    logic              clr_done_s;
    logic              clr_we_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic              wr_ok_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] mem_q [DEPTH];

    rf_clear_seq #(
        .DEPTH     (DEPTH),
        .ZERO_REG0 (ZERO_REG0),
        .ADDR_W    (ADDR_W)
    ) u_clear_seq (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .busy      (busy_s),
        .clr_done  (clr_done_s),
        .clr_we    (clr_we_s),
        .clr_addr  (clr_addr_s)
    );

    // Write qualification: only IDLE cycles without a competing clear request reach the array.
    always_comb begin
        wr_ok_s = 1'b0;
        if (we && !busy_s && !clear_req && !reset &&
            addr_in_range(waddr) && !is_hard_zero(waddr)) begin
            wr_ok_s = 1'b1;
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    // Single array write port shared by the clear sweep and the writeback path.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = waddr;
        mem_wdata_s = wdata;
        if (clr_we_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_addr_s;
            mem_wdata_s = {DATA_W{1'b0}};
        end else if (wr_ok_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = waddr;
            mem_wdata_s = wdata;
        end else begin
            mem_we_s    = 1'b0;
            mem_waddr_s = waddr;
            mem_wdata_s = wdata;
        end
    end

    // Storage array: no reset, contents are defined only by the clear sweep and writes.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // One read/bypass unit per port; both see identical data for the same address.
    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [ADDR_W-1:0] raddr_s;
        logic [DATA_W-1:0] rdata_d;
        logic [DATA_W-1:0] rdata_q;

        assign raddr_s = (p == 0) ? raddr_a : raddr_b;

        // Read priority: forced zero, then same-cycle bypass, then the pre-write array value.
        always_comb begin
            rdata_d = {DATA_W{1'b0}};
            if (busy_s || !addr_in_range(raddr_s) || is_hard_zero(raddr_s)) begin
                rdata_d = {DATA_W{1'b0}};
            end else if (wr_ok_s && (waddr == raddr_s)) begin
                rdata_d = wdata;
            end else begin
                rdata_d = mem_q[raddr_s];
            end
        end

        // Read data register: one cycle of latency, cleared by reset.
        always_ff @(posedge clk) begin
            if (reset) begin
                rdata_q <= {DATA_W{1'b0}};
            end else begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign rdata_a  = g_rd[0].rdata_q;
    assign rdata_b  = g_rd[1].rdata_q;
    assign busy     = busy_s;
    assign clr_done = clr_done_s;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: three instances (16 entries with zero reg, 16
// entries without, 12 entries with zero reg) share write/read stimulus.
module tb_regfile_2r1w;

    logic        clk;
    logic        reset;
    logic        reset_c;
    logic        clear_req;
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  raddr_a;
    logic [3:0]  raddr_b;

    logic        u0_busy, u0_done, u1_busy, u1_done, u2_busy, u2_done;
    logic [31:0] u0_ra, u0_rb, u1_ra, u1_rb, u2_ra, u2_rb;

    int tests_run;
    int tests_failed;

    regfile_2r1w #(.DATA_W(32), .DEPTH(16), .ZERO_REG0(1)) u_z1 (
        .clk(clk), .reset(reset), .clear_req(clear_req), .busy(u0_busy), .clr_done(u0_done),
        .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(u0_ra), .raddr_b(raddr_b), .rdata_b(u0_rb));

    regfile_2r1w #(.DATA_W(32), .DEPTH(16), .ZERO_REG0(0)) u_z0 (
        .clk(clk), .reset(reset), .clear_req(clear_req), .busy(u1_busy), .clr_done(u1_done),
        .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(u1_ra), .raddr_b(raddr_b), .rdata_b(u1_rb));

    regfile_2r1w #(.DATA_W(32), .DEPTH(12), .ZERO_REG0(1)) u_d12 (
        .clk(clk), .reset(reset_c), .clear_req(clear_req), .busy(u2_busy), .clr_done(u2_done),
        .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(u2_ra), .raddr_b(raddr_b), .rdata_b(u2_rb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [31:0] z1_ra;
        logic [31:0] z1_rb;
        logic [31:0] z0_ra;
        logic [31:0] z0_rb;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] z1_ra;
        logic [31:0] z1_rb;
        logic [31:0] z0_ra;
        logic [31:0] z0_rb;
    } exp_t;

    vec_t vecs [10];
    exp_t sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear_req = 1'b0;
        we        = 1'b0;
        waddr     = 4'd0;
        wdata     = 32'h0;
        raddr_a   = 4'd0;
        raddr_b   = 4'd0;
    endtask

    initial begin
        int n_busy [3];
        int n_done [3];
        int bad_z1;
        int bad_z0;
        exp_t e;

        tests_run    = 0;
        tests_failed = 0;

        vecs[0] = '{1'b1, 4'd3,  32'hDEADBEEF, 4'd0,  4'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[1] = '{1'b0, 4'd0,  32'h0,        4'd3,  4'd3,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 4'd5,  32'h00001234, 4'd5,  4'd5,  32'h00001234, 32'h00001234, 32'h00001234, 32'h00001234};
        vecs[3] = '{1'b1, 4'd0,  32'hFFFFFFFF, 4'd3,  4'd5,  32'hDEADBEEF, 32'h00001234, 32'hDEADBEEF, 32'h00001234};
        vecs[4] = '{1'b0, 4'd0,  32'h0,        4'd0,  4'd0,  32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[5] = '{1'b1, 4'd0,  32'h00000011, 4'd0,  4'd3,  32'h0,        32'hDEADBEEF, 32'h00000011, 32'hDEADBEEF};
        vecs[6] = '{1'b1, 4'd3,  32'h0000CAFE, 4'd3,  4'd4,  32'h0000CAFE, 32'h0,        32'h0000CAFE, 32'h0};
        vecs[7] = '{1'b0, 4'd0,  32'h0,        4'd15, 4'd3,  32'h0,        32'h0000CAFE, 32'h0,        32'h0000CAFE};
        vecs[8] = '{1'b1, 4'd15, 32'hA5A5A5A5, 4'd14, 4'd15, 32'h0,        32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5};
        vecs[9] = '{1'b0, 4'd0,  32'h0,        4'd15, 4'd0,  32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 32'h00000011};

        // Reset state and initial sweep length for all three geometries.
        idle_inputs();
        reset   = 1'b1;
        reset_c = 1'b1;
        tick();
        check("rst_z1_busy", {31'h0, u0_busy}, 32'h1);
        check("rst_z0_busy", {31'h0, u1_busy}, 32'h1);
        check("rst_d12_busy", {31'h0, u2_busy}, 32'h1);
        check("rst_z1_done", {31'h0, u0_done}, 32'h0);
        check("rst_z1_ra", u0_ra, 32'h0);
        check("rst_z1_rb", u0_rb, 32'h0);
        check("rst_d12_ra", u2_ra, 32'h0);
        reset   = 1'b0;
        reset_c = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_busy[i] = 0;
            n_done[i] = 0;
        end
        for (int k = 0; k < 25; k++) begin
            if (u0_busy) n_busy[0]++;
            if (u1_busy) n_busy[1]++;
            if (u2_busy) n_busy[2]++;
            if (u0_done) n_done[0]++;
            if (u1_done) n_done[1]++;
            if (u2_done) n_done[2]++;
            tick();
        end
        check("sweep_len_z1", n_busy[0], 32'd15);
        check("sweep_len_z0", n_busy[1], 32'd16);
        check("sweep_len_d12", n_busy[2], 32'd11);
        check("done_cnt_z1", n_done[0], 32'd1);
        check("done_cnt_z0", n_done[1], 32'd1);
        check("done_cnt_d12", n_done[2], 32'd1);

        // Table-driven write/read/bypass/zero-register vectors through the scoreboard.
        for (int i = 0; i < 10; i++) begin
            clear_req = 1'b0;
            we        = vecs[i].we;
            waddr     = vecs[i].waddr;
            wdata     = vecs[i].wdata;
            raddr_a   = vecs[i].ra;
            raddr_b   = vecs[i].rb;
            sb_q.push_back('{i, vecs[i].z1_ra, vecs[i].z1_rb, vecs[i].z0_ra, vecs[i].z0_rb});
            tick();
            e = sb_q.pop_front();
            check($sformatf("vec%0d_z1_ra", e.idx), u0_ra, e.z1_ra);
            check($sformatf("vec%0d_z1_rb", e.idx), u0_rb, e.z1_rb);
            check($sformatf("vec%0d_z0_ra", e.idx), u1_ra, e.z0_ra);
            check($sformatf("vec%0d_z0_rb", e.idx), u1_rb, e.z0_rb);
            check($sformatf("vec%0d_z1_busy", e.idx), {31'h0, u0_busy}, 32'h0);
        end

        // Fill r1..r15, then clear_req collides with a write to r7.
        for (int i = 1; i < 16; i++) begin
            we    = 1'b1;
            waddr = 4'(i);
            wdata = 32'h01010101 * 32'(i);
            tick();
        end
        clear_req = 1'b1;
        we        = 1'b1;
        waddr     = 4'd7;
        wdata     = 32'h00000055;
        raddr_a   = 4'd7;
        raddr_b   = 4'd7;
        tick();
        clear_req = 1'b0;
        check("clrreq_z1_ra_prewrite", u0_ra, 32'h07070707);
        check("clrreq_z1_rb_prewrite", u0_rb, 32'h07070707);
        check("clrreq_z0_ra_prewrite", u1_ra, 32'h07070707);
        for (int i = 0; i < 3; i++) begin
            n_busy[i] = 0;
            n_done[i] = 0;
        end
        bad_z1 = 0;
        bad_z0 = 0;
        for (int k = 0; k < 25; k++) begin
            if (u0_busy) n_busy[0]++;
            if (u1_busy) n_busy[1]++;
            if (u0_done) n_done[0]++;
            if (u1_done) n_done[1]++;
            if (k >= 1 && k <= 15 && u0_ra !== 32'h0) bad_z1++;
            if (k >= 1 && k <= 16 && u1_ra !== 32'h0) bad_z0++;
            clear_req = (k >= 1 && k <= 4);
            we        = u0_busy;
            waddr     = 4'd1;
            wdata     = 32'h00000099;
            tick();
        end
        idle_inputs();
        check("clr2_len_z1", n_busy[0], 32'd15);
        check("clr2_len_z0", n_busy[1], 32'd16);
        check("clr2_done_z1", n_done[0], 32'd1);
        check("clr2_done_z0", n_done[1], 32'd1);
        check("clr2_busy_reads_z1", bad_z1, 32'd0);
        check("clr2_busy_reads_z0", bad_z0, 32'd0);
        for (int i = 0; i < 16; i++) begin
            raddr_a = 4'(i);
            raddr_b = 4'(15 - i);
            tick();
            check($sformatf("after_clr_z1_r%0d", i), u0_ra | u0_rb, 32'h0);
            check($sformatf("after_clr_z0_r%0d", i), u1_ra | u1_rb, 32'h0);
        end

        // Out-of-range address on the 12-entry instance.
        we = 1'b1; waddr = 4'd11; wdata = 32'h000000BB; raddr_a = 4'd13; raddr_b = 4'd13;
        tick();
        check("d12_oor_ra", u2_ra, 32'h0);
        we = 1'b1; waddr = 4'd13; wdata = 32'h00000077; raddr_a = 4'd11; raddr_b = 4'd13;
        tick();
        check("d12_r11_ra", u2_ra, 32'h000000BB);
        check("d12_w13_bypass_rb", u2_rb, 32'h0);
        we = 1'b0; raddr_a = 4'd13; raddr_b = 4'd11;
        tick();
        check("d12_r13_ra", u2_ra, 32'h0);
        check("d12_r11_rb", u2_rb, 32'h000000BB);

        // Reset in sweep cycle 6 restarts the 12-entry sweep from the beginning.
        idle_inputs();
        reset_c = 1'b1;
        tick();
        reset_c = 1'b0;
        repeat (5) tick();
        check("d12_busy_cycle6", {31'h0, u2_busy}, 32'h1);
        check("d12_done_cycle6", {31'h0, u2_done}, 32'h0);
        reset_c = 1'b1;
        tick();
        reset_c = 1'b0;
        n_busy[2] = 0;
        n_done[2] = 0;
        for (int k = 0; k < 20; k++) begin
            if (u2_busy) n_busy[2]++;
            if (u2_done) n_done[2]++;
            tick();
        end
        check("d12_restart_len", n_busy[2], 32'd11);
        check("d12_restart_done", n_done[2], 32'd1);
        raddr_a = 4'd11;
        raddr_b = 4'd11;
        tick();
        check("d12_r11_cleared", u2_ra | u2_rb, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
